// File: rtl/collision_detect.sv
// Bird vs pipe/floor/ceiling detection, game-state FSM and coin counter.
// Coin collection is built only when COLLISION_COIN_EN is defined.
module collision_detect #(
  parameter int BIRD_X_L      = 200,
  parameter int BIRD_X_R      = 229,
  parameter int BIRD_H        = 20,
  parameter int FLOOR_Y       = 460,
  parameter int CEIL_Y        = 0,
  parameter int HIT_CONFIRM   = 2,
  parameter int FREEZE_CYCLES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic [9:0] Bird_Y,
  input  logic [9:0] X_Edge_L,
  input  logic [9:0] X_Edge_R,
  input  logic [9:0] Gap_Top,
  input  logic [9:0] Gap_Bot,
  input  logic [9:0] X_Coin_L,
  input  logic [9:0] X_Coin_R,
  input  logic [9:0] Coin_Y,
  input  logic       shift_Coin,
  output logic       Stop,
  output logic       Done,
  output logic       Coin_Hit,
  output logic [3:0] Coins,
  output logic       Q_Initial,
  output logic       Q_Run,
  output logic       Q_Hit,
  output logic       Q_Done
);

  localparam logic [9:0] XL = 10'(BIRD_X_L);
  localparam logic [9:0] XR = 10'(BIRD_X_R);

  typedef enum logic [3:0] {
    QInitial = 4'b0001,
    QRun     = 4'b0010,
    QHit     = 4'b0100,
    QDone    = 4'b1000
  } state_e;

  state_e      state_q;
  logic [2:0]  hit_cnt_q;
  logic [7:0]  frz_cnt_q;
  logic        stop_q;
  logic        done_q;

  logic [10:0] bot;
  logic        xo;
  logic        pipe_hit;
  logic        bound_hit;
  logic        raw;

  assign bot       = {1'b0, Bird_Y} + 11'(BIRD_H);
  assign xo        = (X_Edge_L <= XR) && (X_Edge_R >= XL);
  assign pipe_hit  = xo && ((Bird_Y < Gap_Top) ||
                            (bot > {1'b0, Gap_Bot}));
  assign bound_hit = (bot >= 11'(FLOOR_Y)) ||
                     (Bird_Y <= 10'(CEIL_Y));
  assign raw       = pipe_hit | bound_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= QInitial;
      hit_cnt_q <= '0;
      frz_cnt_q <= '0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        QInitial: begin
          hit_cnt_q <= '0;
          frz_cnt_q <= '0;
          stop_q    <= 1'b0;
          done_q    <= 1'b0;
          if (Start) state_q <= QRun;
        end
        QRun: begin
          if (raw) begin
            hit_cnt_q <= hit_cnt_q + 3'd1;
            if (hit_cnt_q == 3'(HIT_CONFIRM - 1)) begin
              state_q   <= QHit;
              stop_q    <= 1'b1;
              frz_cnt_q <= '0;
            end
          end else begin
            hit_cnt_q <= '0;
          end
        end
        QHit: begin
          stop_q    <= 1'b1;
          frz_cnt_q <= frz_cnt_q + 8'd1;
          if (frz_cnt_q == 8'(FREEZE_CYCLES - 1)) begin
            state_q <= QDone;
            done_q  <= 1'b1;
          end
        end
        QDone: begin
          if (Ack) begin
            state_q <= QInitial;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= QInitial;
          stop_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Stop      = stop_q;
  assign Done      = done_q;
  assign Q_Initial = state_q[0];
  assign Q_Run     = state_q[1];
  assign Q_Hit     = state_q[2];
  assign Q_Done    = state_q[3];

`ifdef COLLISION_COIN_EN
  logic [10:0] coin_bot;
  logic [10:0] bird_last;
  logic        coin_ov;
  logic        taken_q;
  logic        coin_hit_q;
  logic [3:0]  coins_q;

  // Bird occupies rows Bird_Y .. Bird_Y+BIRD_H-1
  assign coin_bot  = {1'b0, Coin_Y} + 11'd19;
  assign bird_last = bot - 11'd1;
  assign coin_ov   = (X_Coin_L <= XR) && (X_Coin_R >= XL) &&
                     ({1'b0, Bird_Y} <= coin_bot) &&
                     (bird_last >= {1'b0, Coin_Y});

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q    <= 1'b0;
      coin_hit_q <= 1'b0;
      coins_q    <= '0;
    end else begin
      coin_hit_q <= 1'b0;
      if (state_q == QInitial) begin
        coins_q <= '0;
        taken_q <= 1'b0;
      end else if (shift_Coin) begin
        taken_q <= 1'b0;
      end else if (state_q == QRun && coin_ov && !taken_q) begin
        coin_hit_q <= 1'b1;
        taken_q    <= 1'b1;
        if (coins_q != 4'd15) coins_q <= coins_q + 4'd1;
      end
    end
  end

  assign Coin_Hit = coin_hit_q;
  assign Coins    = coins_q;
`else
  logic unused_coin;
  assign unused_coin = ^{X_Coin_L, X_Coin_R, Coin_Y, shift_Coin};
  assign Coin_Hit    = 1'b0;
  assign Coins       = 4'd0;
`endif

endmodule

// File: tb/tb_collision_detect.sv
// Bench for collision_detect: vector table, directed sequences
// and a randomized run against a behavioural game model.
module tb_collision_detect;

`ifdef COLLISION_COIN_EN
  localparam bit COIN_EN = 1'b1;
`else
  localparam bit COIN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, Start, Ack, shift_Coin;
  logic [9:0] Bird_Y, X_Edge_L, X_Edge_R, Gap_Top, Gap_Bot;
  logic [9:0] X_Coin_L, X_Coin_R, Coin_Y;
  logic       Stop, Done, Coin_Hit;
  logic [3:0] Coins;
  logic       Q_Initial, Q_Run, Q_Hit, Q_Done;

  always #5 clk = ~clk;

  collision_detect dut (
    .clk(clk), .reset(reset), .Start(Start), .Ack(Ack),
    .Bird_Y(Bird_Y), .X_Edge_L(X_Edge_L), .X_Edge_R(X_Edge_R),
    .Gap_Top(Gap_Top), .Gap_Bot(Gap_Bot),
    .X_Coin_L(X_Coin_L), .X_Coin_R(X_Coin_R), .Coin_Y(Coin_Y),
    .shift_Coin(shift_Coin),
    .Stop(Stop), .Done(Done), .Coin_Hit(Coin_Hit), .Coins(Coins),
    .Q_Initial(Q_Initial), .Q_Run(Q_Run),
    .Q_Hit(Q_Hit), .Q_Done(Q_Done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic safe_inputs();
    Start = 0; Ack = 0; shift_Coin = 0;
    Bird_Y = 10'd200;
    X_Edge_L = 10'd640; X_Edge_R = 10'd701;
    Gap_Top = 10'd150;  Gap_Bot = 10'd260;
    X_Coin_L = 10'd640; X_Coin_R = 10'd660;
    Coin_Y = 10'd0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic start_run();
    Start = 1; tick(); Start = 0;
  endtask

  typedef struct {
    int y; int l; int r; int gt; int gb; bit hit;
  } vec_t;
  vec_t tbl[16];

  // Behavioural game model: mode 0 idle, 1 playing, 2 frozen, 3 over
  int m_mode, m_streak, m_frz, m_coins;
  bit m_taken, m_pulse;

  function automatic bit spans(int a_l, int a_r, int b_l, int b_r);
    int lo, hi;
    lo = (a_l > b_l) ? a_l : b_l;
    hi = (a_r < b_r) ? a_r : b_r;
    return lo <= hi;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_streak = 0; m_frz = 0;
    m_coins = 0; m_taken = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int y, dy;
    bit xo, raw, cov;
    if (reset) begin
      model_reset();
      return;
    end
    y   = int'(Bird_Y);
    xo  = spans(int'(X_Edge_L), int'(X_Edge_R), 200, 229);
    raw = (xo && (y < int'(Gap_Top) || y + 20 > int'(Gap_Bot)))
          || (y + 20 >= 460) || (y <= 0);
    dy  = y - int'(Coin_Y);
    if (dy < 0) dy = -dy;
    cov = spans(int'(X_Coin_L), int'(X_Coin_R), 200, 229)
          && (dy <= 19);
    m_pulse = 0;
    if (m_mode == 0) begin
      m_coins = 0; m_taken = 0;
    end else begin
      m_pulse = (m_mode == 1) && cov && !m_taken && !shift_Coin;
      if (shift_Coin) m_taken = 0;
      if (m_pulse) begin
        m_taken = 1;
        if (m_coins < 15) m_coins++;
      end
    end
    case (m_mode)
      0: if (Start) begin m_mode = 1; m_streak = 0; end
      1: begin
        m_streak = raw ? m_streak + 1 : 0;
        if (m_streak == 2) begin m_mode = 2; m_frz = 0; end
      end
      2: begin
        m_frz++;
        if (m_frz == 60) m_mode = 3;
      end
      default: if (Ack) m_mode = 0;
    endcase
  endtask

  function automatic logic [9:0] clampv(int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  initial begin
    int pulses;
    int y;
    reset = 0;
    safe_inputs();

    do_reset();
    chk("rst_qinit", Q_Initial, 1);
    chk("rst_qrun", Q_Run, 0);
    chk("rst_stop", Stop, 0);
    chk("rst_done", Done, 0);
    chk("rst_coins", Coins, 0);
    chk("rst_coinhit", Coin_Hit, 0);
    start_run();
    chk("start_qrun", Q_Run, 1);
    chk("start_stop", Stop, 0);
    chk("start_coins", Coins, 0);

    tbl[0]  = '{200, 210, 271, 150, 260, 1'b0};
    tbl[1]  = '{250, 210, 271, 150, 260, 1'b1};
    tbl[2]  = '{140, 210, 271, 150, 260, 1'b1};
    tbl[3]  = '{150, 210, 271, 150, 260, 1'b0};
    tbl[4]  = '{240, 210, 271, 150, 260, 1'b0};
    tbl[5]  = '{241, 210, 271, 150, 260, 1'b1};
    tbl[6]  = '{250, 640, 701, 150, 260, 1'b0};
    tbl[7]  = '{250, 230, 300, 150, 260, 1'b0};
    tbl[8]  = '{250, 229, 300, 150, 260, 1'b1};
    tbl[9]  = '{250, 100, 199, 150, 260, 1'b0};
    tbl[10] = '{250, 100, 200, 150, 260, 1'b1};
    tbl[11] = '{439, 640, 701, 150, 260, 1'b0};
    tbl[12] = '{440, 640, 701, 150, 260, 1'b1};
    tbl[13] = '{0,   640, 701, 150, 260, 1'b1};
    tbl[14] = '{1,   640, 701, 150, 260, 1'b0};
    tbl[15] = '{1000, 640, 701, 150, 260, 1'b1};

    foreach (tbl[i]) begin
      safe_inputs();
      do_reset();
      start_run();
      Bird_Y   = 10'(tbl[i].y);
      X_Edge_L = 10'(tbl[i].l);
      X_Edge_R = 10'(tbl[i].r);
      Gap_Top  = 10'(tbl[i].gt);
      Gap_Bot  = 10'(tbl[i].gb);
      tick();
      chk($sformatf("vec%0d_early", i), Stop, 0);
      tick();
      chk($sformatf("vec%0d_stop", i), Stop, 32'(tbl[i].hit));
      chk($sformatf("vec%0d_qhit", i), Q_Hit, 32'(tbl[i].hit));
    end

    // Safe flight, then drop below the gap
    safe_inputs();
    do_reset();
    start_run();
    X_Edge_L = 10'd210; X_Edge_R = 10'd271;
    repeat (5) tick();
    chk("seq2_safe", Stop, 0);
    Bird_Y = 10'd250;
    tick();
    chk("seq2_lat1", Stop, 0);
    tick();
    chk("seq2_lat2", Stop, 1);

    // Single-cycle overlap must not stick
    safe_inputs();
    do_reset();
    start_run();
    Bird_Y = 10'd250; X_Edge_L = 10'd210; X_Edge_R = 10'd271;
    tick();
    X_Edge_L = 10'd640; X_Edge_R = 10'd701;
    tick();
    chk("seq3_gone1", Stop, 0);
    tick();
    chk("seq3_gone2", Stop, 0);
    X_Edge_L = 10'd210; X_Edge_R = 10'd271;
    tick();
    chk("seq3_recount", Stop, 0);
    tick();
    chk("seq3_hit", Stop, 1);

    // Floor hit, freeze length, Ack handling
    safe_inputs();
    do_reset();
    start_run();
    Bird_Y = 10'd445;
    tick();
    chk("seq4_lat1", Stop, 0);
    tick();
    chk("seq4_stop", Stop, 1);
    chk("seq4_qhit", Q_Hit, 1);
    Ack = 1; Start = 1;
    repeat (59) tick();
    chk("seq4_frz59_qhit", Q_Hit, 1);
    chk("seq4_frz59_done", Done, 0);
    tick();
    chk("seq4_done", Done, 1);
    chk("seq4_qdone", Q_Done, 1);
    chk("seq4_done_stop", Stop, 1);
    Ack = 0; Start = 0;
    tick();
    chk("seq4_hold", Q_Done, 1);
    Ack = 1;
    tick();
    chk("seq4_ack_qinit", Q_Initial, 1);
    chk("seq4_ack_stop", Stop, 0);
    chk("seq4_ack_done", Done, 0);
    Ack = 0;

    // Coin collection
    safe_inputs();
    do_reset();
    start_run();
    X_Coin_L = 10'd205; X_Coin_R = 10'd225; Coin_Y = 10'd200;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (Coin_Hit) pulses++;
    end
    chk("coin_pulses", pulses, COIN_EN ? 1 : 0);
    chk("coin_cnt1", Coins, COIN_EN ? 1 : 0);
`ifdef COLLISION_COIN_EN
    shift_Coin = 1;
    tick();
    chk("coin_shift_nocredit", Coin_Hit, 0);
    shift_Coin = 0;
    tick();
    chk("coin_second_pulse", Coin_Hit, 1);
    chk("coin_cnt2", Coins, 2);
    for (int k = 0; k < 3; k++) begin
      shift_Coin = 1; tick(); shift_Coin = 0; tick();
    end
    chk("coin_cnt5", Coins, 5);
`endif

    // Reset in the middle of a game
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midrst_qinit", Q_Initial, 1);
    chk("midrst_coins", Coins, 0);
    chk("midrst_stop", Stop, 0);

`ifdef COLLISION_COIN_EN
    start_run();
    for (int k = 0; k < 16; k++) begin
      shift_Coin = 1; tick(); shift_Coin = 0; tick();
    end
    chk("coin_sat", Coins, 15);
`endif

    // Randomized play against the model
    safe_inputs();
    do_reset();
    model_reset();
    for (int c = 0; c < 5000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      Start = ($urandom_range(0, 4) == 0);
      Ack   = ($urandom_range(0, 4) == 0);
      shift_Coin = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 19))
        0: y = 0;
        1: y = $urandom_range(435, 470);
        2: y = $urandom_range(0, 1023);
        default: y = $urandom_range(30, 420);
      endcase
      Bird_Y = 10'(y);
      if ($urandom_range(0, 2) == 0) begin
        X_Edge_L = 10'd640;
      end else begin
        X_Edge_L = 10'($urandom_range(130, 240));
      end
      X_Edge_R = X_Edge_L + 10'd61;
      Gap_Top  = clampv(y + $urandom_range(0, 40) - 36);
      Gap_Bot  = clampv(y + 20 + $urandom_range(0, 40) - 4);
      X_Coin_L = 10'($urandom_range(170, 240));
      X_Coin_R = X_Coin_L + 10'd20;
      Coin_Y   = clampv(y + $urandom_range(0, 50) - 25);
      model_step();
      tick();
      chk($sformatf("rnd%0d_state", c),
          {Q_Initial, Q_Run, Q_Hit, Q_Done},
          32'(4'b1000 >> m_mode));
      chk($sformatf("rnd%0d_stop", c), Stop, 32'(m_mode >= 2));
      chk($sformatf("rnd%0d_done", c), Done, 32'(m_mode == 3));
      chk($sformatf("rnd%0d_coinhit", c), Coin_Hit,
          COIN_EN ? 32'(m_pulse) : 0);
      chk($sformatf("rnd%0d_coins", c), Coins,
          COIN_EN ? m_coins : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
